// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: PC register write-back, instruction-memory port, decode handshake, redirect.
// Latency: none (wiring only).
// Backpressure: the ir_valid/ir_ready and imem_req/imem_ack pairs carry all flow control.
interface inst_fetch_if #(
    parameter int AW = 32,
    parameter int IW = 32
);
    logic [AW-1:0] pc_in;
    logic          PCWre;
    logic [AW-1:0] PCin;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          ir_valid;
    logic          ir_ready;
    logic [IW-1:0] ir_data;
    logic [AW-1:0] ir_pc;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          fetch_fault;

    // Fetch unit side
    modport master (
        input  pc_in, imem_ack, imem_rdata, ir_ready, branch_taken, branch_target,
        output PCWre, PCin, imem_req, imem_addr, ir_valid, ir_data, ir_pc, fetch_fault
    );

    // PC register / IMEM / decode / execute side
    modport slave (
        output pc_in, imem_ack, imem_rdata, ir_ready, branch_taken, branch_target,
        input  PCWre, PCin, imem_req, imem_addr, ir_valid, ir_data, ir_pc, fetch_fault
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: reads the PC, fetches one word from IMEM, hands it to decode, writes next PC.
// Latency: one instruction per 3 cycles with a 1-cycle ack; all outputs registered.
// Backpressure: holds ir_data/ir_pc until decode handshakes; no new fetch while an instruction waits.
module inst_fetch #(
    parameter int AW   = 32,
    parameter int IW   = 32,
    parameter int STEP = 4
) (
    input  logic clk,
    input  logic reset,
    inst_fetch_if.master bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] HOLD   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] SETTLE = 3'd4;
    localparam logic [2:0] FAULT  = 3'd5;

    logic [2:0]    state;
    logic [AW-1:0] addr_q;
    logic          go_entry;
    logic          misaligned;

    // Decide when a new fetch may start. pc_in is only trusted once the PC register
    // has absorbed any PCWre pulse, so entry is held off while PCWre is high; after a
    // redirect this makes SETTLE cover the pulse cycle plus the absorb cycle.
    always_comb begin
        go_entry   = 1'b0;
        misaligned = (bus.pc_in[1:0] != 2'b00);
        case (state)
            IDLE:    go_entry = 1'b1;
            SETTLE:  go_entry = !bus.PCWre;
            HOLD:    go_entry = bus.ir_ready && !bus.PCWre;
            default: go_entry = 1'b0;
        endcase
    end

    // Fetch FSM and all registered outputs; a redirect outranks every other event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addr_q        <= '0;
            bus.PCWre     <= 1'b0;
            bus.PCin      <= '0;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= '0;
            bus.ir_valid  <= 1'b0;
            bus.ir_data   <= '0;
            bus.ir_pc     <= '0;
            bus.fetch_fault <= 1'b0;
        end else begin
            bus.PCWre <= 1'b0;
            if (bus.branch_taken && state != IDLE) begin
                // Redirect: write the target, flush any held instruction, clear a fault.
                bus.PCWre       <= 1'b1;
                bus.PCin        <= bus.branch_target;
                bus.ir_valid    <= 1'b0;
                bus.fetch_fault <= 1'b0;
                if (state == FETCH || state == DRAIN) begin
                    if (bus.imem_ack) begin
                        // Memory finished this cycle; its data is dropped.
                        bus.imem_req <= 1'b0;
                        state        <= SETTLE;
                    end else begin
                        // Memory still busy; keep the request stable until it completes.
                        state <= DRAIN;
                    end
                end else begin
                    state <= SETTLE;
                end
            end else if (go_entry) begin
                bus.ir_valid <= 1'b0;
                if (misaligned) begin
                    bus.fetch_fault <= 1'b1;
                    state           <= FAULT;
                end else begin
                    addr_q        <= bus.pc_in;
                    bus.imem_addr <= bus.pc_in;
                    bus.imem_req  <= 1'b1;
                    state         <= FETCH;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (bus.imem_ack) begin
                            bus.ir_data  <= bus.imem_rdata;
                            bus.ir_pc    <= addr_q;
                            bus.ir_valid <= 1'b1;
                            bus.PCWre    <= 1'b1;
                            bus.PCin     <= addr_q + AW'(STEP);
                            bus.imem_req <= 1'b0;
                            state        <= HOLD;
                        end
                    end
                    DRAIN: begin
                        if (bus.imem_ack) begin
                            bus.imem_req <= 1'b0;
                            state        <= SETTLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed cases then randomized fetch/redirect traffic.
// Latency: n/a.
// Backpressure: decode ready and memory ack latency are driven from the stimulus.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // PC register model: loads PCin on PCWre; the bench may overwrite it to plant odd PCs.
    logic [31:0] pc_reg, pc_init, force_val;
    logic        force_pc;
    always @(posedge clk or posedge reset) begin
        if (reset)         pc_reg <= pc_init;
        else if (force_pc) pc_reg <= force_val;
        else if (bus.PCWre) pc_reg <= bus.PCin;
    end
    assign bus.pc_in = pc_reg;

    int n_checks = 0;
    int n_fail   = 0;

    // PCWre pulse counting, sampled mid-cycle.
    int   pcwre_cnt  = 0;
    int   dbl_cnt    = 0;
    logic pcwre_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.PCWre) begin
            pcwre_cnt++;
            if (pcwre_prev) dbl_cnt++;
        end
        pcwre_prev = bus.PCWre;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h8C01_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {bus.PCWre, bus.imem_req, bus.ir_valid, bus.fetch_fault}, 64'd0);
        check({tag, "_PCin"}, bus.PCin, 64'd0);
        check({tag, "_addr"}, bus.imem_addr, 64'd0);
        check({tag, "_irdata"}, bus.ir_data, 64'd0);
        check({tag, "_irpc"}, bus.ir_pc, 64'd0);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !bus.imem_req; i++) tick();
        check(tag, bus.imem_req, 64'd1);
    endtask

    task automatic accept(input string tag);
        bus.ir_ready = 1'b1;
        for (int i = 0; i < 10 && bus.ir_valid; i++) tick();
        bus.ir_ready = 1'b0;
        check(tag, bus.ir_valid, 64'd0);
    endtask

    initial begin
        int          base;
        int          mode;
        logic [31:0] tgt;
        logic [31:0] exp_addr;

        reset = 1'b0;
        force_pc = 1'b0;
        force_val = '0;
        pc_init = 32'h100;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.ir_ready = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        #1 reset = 1'b1;
        #2;
        check_zero("reset");
        tick();
        tick();
        reset = 1'b0;

        // 1: basic fetch, ack two cycles after request
        wait_req("t1_req");
        check("t1_addr", bus.imem_addr, 64'h100);
        base = pcwre_cnt;
        tick();
        tick();
        check("t1_req_held", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h100});
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h8C01_0004;
        tick();
        bus.imem_ack = 1'b0;
        check("t1_ir", {bus.ir_valid, bus.ir_data}, {1'b1, 32'h8C01_0004});
        check("t1_irpc", bus.ir_pc, 64'h100);
        check("t1_pcwre", {bus.PCWre, bus.PCin}, {1'b1, 32'h104});

        // 2: decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stable", {bus.ir_valid, bus.ir_data, bus.ir_pc}, {1'b1, 32'h8C01_0004, 32'h100});
            check("t2_noreq", {bus.imem_req, bus.PCWre}, 64'd0);
        end
        check("t2_one_pulse", pcwre_cnt - base, 64'd1);
        accept("t2_accept");
        wait_req("t2_req");
        check("t2_addr", bus.imem_addr, 64'h104);

        // 3: branch while waiting for ack
        base = pcwre_cnt;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h200;
        tick();
        bus.branch_taken = 1'b0;
        check("t3_pulse", {bus.PCWre, bus.PCin}, {1'b1, 32'h200});
        check("t3_hold", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h104});
        tick();
        tick();
        check("t3_hold2", {bus.ir_valid, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, 32'h104});
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 1'b0;
        check("t3_drop", {bus.ir_valid, bus.imem_req}, 64'd0);
        wait_req("t3_req");
        check("t3_addr", bus.imem_addr, 64'h200);
        check("t3_pulses", pcwre_cnt - base, 64'd1);

        // 4: branch in the same cycle as ack
        base = pcwre_cnt;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h200;
        tick();
        bus.imem_ack = 1'b0;
        bus.branch_taken = 1'b0;
        check("t4_drop", {bus.ir_valid, bus.imem_req}, 64'd0);
        check("t4_pulse", {bus.PCWre, bus.PCin}, {1'b1, 32'h200});
        wait_req("t4_req");
        check("t4_addr", bus.imem_addr, 64'h200);
        check("t4_pulses", pcwre_cnt - base, 64'd1);

        // 5: misaligned PC faults, branch recovers
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(32'h200);
        tick();
        bus.imem_ack = 1'b0;
        tick();
        force_pc = 1'b1;
        force_val = 32'h102;
        tick();
        force_pc = 1'b0;
        accept("t5_accept");
        check("t5_fault", {bus.fetch_fault, bus.imem_req, bus.ir_valid}, 64'b100);
        tick();
        tick();
        tick();
        check("t5_fault_sticky", {bus.fetch_fault, bus.imem_req, bus.PCWre}, 64'b100);
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h300;
        tick();
        bus.branch_taken = 1'b0;
        check("t5_clear", {bus.fetch_fault, bus.PCWre, bus.PCin}, {1'b0, 1'b1, 32'h300});
        wait_req("t5_req");
        check("t5_addr", bus.imem_addr, 64'h300);

        // 6: PC wrap, then reset with a request outstanding
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(32'h300);
        tick();
        bus.imem_ack = 1'b0;
        tick();
        force_pc = 1'b1;
        force_val = 32'hFFFF_FFFC;
        tick();
        force_pc = 1'b0;
        accept("t6_accept");
        wait_req("t6_req");
        check("t6_addr", bus.imem_addr, 64'hFFFF_FFFC);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hCAFE_0001;
        tick();
        bus.imem_ack = 1'b0;
        check("t6_wrap", {bus.PCWre, bus.PCin}, {1'b1, 32'h0});
        check("t6_irpc", bus.ir_pc, 64'hFFFF_FFFC);
        accept("t6_accept2");
        wait_req("t6_req0");
        check("t6_addr0", bus.imem_addr, 64'h0);
        #2;
        reset = 1'b1;
        bus.imem_ack = 1'b1;
        #1;
        check_zero("t6_rst");
        tick();
        tick();
        check("t6_ack_ignored", {bus.ir_valid, bus.PCWre, bus.imem_req}, 64'd0);
        bus.imem_ack = 1'b0;
        pc_init = $urandom & 32'hFFFF_FFFC;
        tick();
        reset = 1'b0;

        // Randomized traffic against a transaction-level PC model
        exp_addr = pc_init;
        base = pcwre_cnt;
        for (int t = 0; t < 30; t++) begin
            mode = $urandom_range(0, 4);
            wait_req("rnd_req");
            check("rnd_addr", bus.imem_addr, {32'h0, exp_addr});
            repeat ($urandom_range(0, 3)) tick();
            if (mode >= 3) begin
                tgt = $urandom & 32'hFFFF_FFFC;
                bus.branch_taken = 1'b1;
                bus.branch_target = tgt;
                if (mode == 4) begin
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = $urandom;
                end
                tick();
                bus.branch_taken = 1'b0;
                bus.imem_ack = 1'b0;
                check("rnd_br_pulse", {bus.PCWre, bus.PCin}, {1'b1, tgt});
                if (mode == 3) begin
                    repeat ($urandom_range(0, 2)) tick();
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = $urandom;
                    tick();
                    bus.imem_ack = 1'b0;
                end
                check("rnd_drop", {bus.ir_valid, bus.imem_req}, 64'd0);
                exp_addr = tgt;
            end else begin
                bus.imem_ack = 1'b1;
                bus.imem_rdata = mem_word(exp_addr);
                tick();
                bus.imem_ack = 1'b0;
                check("rnd_ir", {bus.ir_valid, bus.ir_data}, {1'b1, mem_word(exp_addr)});
                check("rnd_irpc", bus.ir_pc, {32'h0, exp_addr});
                check("rnd_seq", {bus.PCWre, bus.PCin}, {1'b1, exp_addr + 32'd4});
                repeat ($urandom_range(0, 3)) tick();
                accept("rnd_accept");
                exp_addr = exp_addr + 32'd4;
            end
        end
        tick();
        check("rnd_pulses", pcwre_cnt - base, 64'd30);
        check("rnd_no_double", dbl_cnt, 64'd0);

        // 7: back-to-back branches, newest target wins
        wait_req("t7_req");
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h400;
        tick();
        bus.branch_target = 32'h480;
        tick();
        bus.branch_taken = 1'b0;
        check("t7_pulse", {bus.PCWre, bus.PCin}, {1'b1, 32'h480});
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        wait_req("t7_req2");
        check("t7_addr", bus.imem_addr, 64'h480);
        check("t7_double", dbl_cnt, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
